// File: rtl/config_pkg.sv
// Shared sizing, data types and FSM encoding for the vector load/store unit.
package config_pkg;

  localparam int D      = 8;            // elements per vector register
  localparam int IDX_W  = $clog2(D);    // element index width
  localparam int DATA_W = 16;           // one element == one DDR word
  localparam int ADDR_W = 8;            // DDR word address width

  typedef logic signed [DATA_W-1:0] fixed_point_t;
  typedef fixed_point_t [D-1:0]     vector_t;
  typedef logic [ADDR_W-1:0]        ddr_address_t;
  typedef logic [DATA_W-1:0]        ddr_data_t;

  // Encodings 2'd2/2'd3 are not operations; they complete as no-ops.
  typedef enum logic [1:0] {
    LDV = 2'd0,
    SV  = 2'd1
  } load_store_operation_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SV_READ  = 3'd1,
    SV_REQ   = 3'd2,
    SV_WAIT  = 3'd3,
    LD_REQ   = 3'd4,
    LD_WAIT  = 3'd5,
    LD_WRITE = 3'd6
  } ls_state_e;

endpackage

// File: rtl/vector_load_store.sv
// Moves a whole vector register to/from DDR one element per word, keeping at
// most one DDR request in flight. A single data register carries the element
// in both directions.
module vector_load_store
  import config_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  load_store_operation_t vector_operation_i,
  input  ddr_address_t          vector_memory_address_i,
  output logic [IDX_W-1:0]      vector_addr_o,
  output logic                  vector_w_en_o,
  output fixed_point_t          vector_w_data_o,
  input  fixed_point_t          vector_r_data_i,
  output ddr_address_t          ddr_address_o,
  output logic                  ddr_w_en_o,
  output ddr_data_t             ddr_w_data_o,
  input  logic                  ddr_w_done_i,
  output logic                  ddr_r_en_o,
  input  ddr_data_t             ddr_r_data_i,
  input  logic                  ddr_r_valid_i
);

  ls_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  ddr_address_t     base_q, base_d;
  ddr_data_t        data_q, data_d;
  logic             last_elem;

  assign last_elem = (idx_q == IDX_W'(D - 1));

  // State register: reset aborts any command and clears all datapath state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

  // Next-state: sequence each element; responses only count in the wait states.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          base_d = vector_memory_address_i;
          idx_d  = '0;
          case (vector_operation_i)
            SV:      state_d = SV_READ;
            LDV:     state_d = LD_REQ;
            default: state_d = IDLE;   // unknown op: done on accept
          endcase
        end
      end
      SV_READ: begin
        data_d  = ddr_data_t'(vector_r_data_i);
        state_d = SV_REQ;
      end
      SV_REQ:  state_d = SV_WAIT;
      SV_WAIT: begin
        if (ddr_w_done_i) begin
          if (last_elem) state_d = IDLE;
          else begin
            idx_d   = idx_q + 1'b1;
            state_d = SV_READ;
          end
        end
      end
      LD_REQ:  state_d = LD_WAIT;
      LD_WAIT: begin
        if (ddr_r_valid_i) begin
          data_d  = ddr_r_data_i;
          state_d = LD_WRITE;
        end
      end
      LD_WRITE: begin
        if (last_elem) state_d = IDLE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = LD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: strobes decoded from state, address/data straight from registers.
  always_comb begin
    in_ready_o      = (state_q == IDLE);
    ddr_w_en_o      = (state_q == SV_REQ);
    ddr_r_en_o      = (state_q == LD_REQ);
    vector_w_en_o   = (state_q == LD_WRITE);
    vector_addr_o   = idx_q;
    ddr_address_o   = base_q + ddr_address_t'(idx_q);  // wraps modulo width
    ddr_w_data_o    = data_q;
    vector_w_data_o = fixed_point_t'(data_q);
  end

endmodule

// File: tb/tb_vector_load_store.sv
// Directed bench: DDR and vector-register models with 2-cycle DDR latency.
module tb_vector_load_store;
  import config_pkg::*;

  localparam int MEM_N = 1 << ADDR_W;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  load_store_operation_t vector_operation_i;
  ddr_address_t          vector_memory_address_i;
  logic [IDX_W-1:0]      vector_addr_o;
  logic                  vector_w_en_o;
  fixed_point_t          vector_w_data_o;
  fixed_point_t          vector_r_data_i;
  ddr_address_t          ddr_address_o;
  logic                  ddr_w_en_o;
  ddr_data_t             ddr_w_data_o;
  logic                  ddr_w_done_i;
  logic                  ddr_r_en_o;
  ddr_data_t             ddr_r_data_i;
  logic                  ddr_r_valid_i;

  vector_load_store dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .vector_operation_i(vector_operation_i),
    .vector_memory_address_i(vector_memory_address_i),
    .vector_addr_o(vector_addr_o), .vector_w_en_o(vector_w_en_o),
    .vector_w_data_o(vector_w_data_o), .vector_r_data_i(vector_r_data_i),
    .ddr_address_o(ddr_address_o), .ddr_w_en_o(ddr_w_en_o),
    .ddr_w_data_o(ddr_w_data_o), .ddr_w_done_i(ddr_w_done_i),
    .ddr_r_en_o(ddr_r_en_o), .ddr_r_data_i(ddr_r_data_i),
    .ddr_r_valid_i(ddr_r_valid_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory images; the seeds double as the expected contents.
  fixed_point_t vec [D];
  fixed_point_t vec_seed [D];
  ddr_data_t    ddr_mem [MEM_N];
  ddr_data_t    ddr_seed [MEM_N];
  logic         init_v = 1'b0, init_d = 1'b0, clr = 1'b0;
  int           w_cnt, r_cnt, vw_cnt;
  int           wlog [$];
  logic         r_dly, w_dly;
  ddr_address_t r_addr;

  assign vector_r_data_i = vec[vector_addr_o];

  // Responder: DDR answers 2 cycles after a request; vector writes land at the edge.
  always @(posedge clk_i) begin
    ddr_r_valid_i <= r_dly;
    ddr_r_data_i  <= ddr_mem[r_addr];
    ddr_w_done_i  <= w_dly;
    r_dly  <= ddr_r_en_o;
    r_addr <= ddr_address_o;
    w_dly  <= ddr_w_en_o;
    if (init_v) vec <= vec_seed;
    if (init_d) ddr_mem <= ddr_seed;
    if (ddr_w_en_o) ddr_mem[ddr_address_o] <= ddr_w_data_o;
    if (vector_w_en_o) vec[vector_addr_o] <= vector_w_data_o;
    if (clr) begin
      w_cnt <= 0; r_cnt <= 0; vw_cnt <= 0;
      wlog.delete();
    end else begin
      if (ddr_w_en_o) begin
        w_cnt <= w_cnt + 1;
        wlog.push_back(int'(ddr_address_o));
      end
      if (ddr_r_en_o) r_cnt <= r_cnt + 1;
      if (vector_w_en_o) vw_cnt <= vw_cnt + 1;
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic clear_counts();
    clr = 1'b1; tick(1); clr = 1'b0;
  endtask

  task automatic seed_vec();
    for (int i = 0; i < D; i++) vec_seed[i] = fixed_point_t'($urandom_range(16'hffff));
    init_v = 1'b1; tick(1); init_v = 1'b0;
  endtask

  task automatic seed_ddr();
    for (int i = 0; i < MEM_N; i++) ddr_seed[i] = ddr_data_t'($urandom_range(16'hffff));
    init_d = 1'b1; tick(1); init_d = 1'b0;
  endtask

  // Issue one command and wait (bounded) for in_ready_o to come back.
  task automatic run_cmd(input load_store_operation_t op, input ddr_address_t base,
                         output int cycles);
    in_valid_i = 1'b1; vector_operation_i = op; vector_memory_address_i = base;
    tick(1);
    in_valid_i = 1'b0;
    cycles = 1;
    while (!in_ready_o && cycles < 20 * D) begin tick(1); cycles++; end
    chk("done_in_time", {31'b0, in_ready_o}, 32'd1);
  endtask

  task automatic check_ldv();
    for (int i = 0; i < D; i++)
      chk($sformatf("ldv_elem%0d", i), 32'(ddr_data_t'(vec[i])), 32'(ddr_data_t'(ddr_seed[(i + int'(vector_memory_address_i)) % MEM_N])));
  endtask

  task automatic check_sv(input int base);
    for (int i = 0; i < D; i++)
      chk($sformatf("sv_elem%0d", i), 32'(ddr_mem[(base + i) % MEM_N]), 32'(ddr_data_t'(vec_seed[i])));
  endtask

  initial begin
    int cyc, total;
    rst_i = 1'b1; in_valid_i = 1'b0; vector_operation_i = LDV; vector_memory_address_i = '0;
    r_dly = 1'b0; w_dly = 1'b0; r_addr = '0;
    ddr_r_valid_i = 1'b0; ddr_w_done_i = 1'b0; ddr_r_data_i = '0;
    w_cnt = 0; r_cnt = 0; vw_cnt = 0;
    for (int i = 0; i < D; i++) begin vec[i] = '0; vec_seed[i] = '0; end
    for (int i = 0; i < MEM_N; i++) begin ddr_mem[i] = '0; ddr_seed[i] = '0; end
    tick(2);
    rst_i = 1'b0;

    // Reset state
    chk("rst_ready",  {31'b0, in_ready_o}, 32'd1);
    chk("rst_enables", {29'b0, vector_w_en_o, ddr_w_en_o, ddr_r_en_o}, 32'd0);
    chk("rst_ddr_addr", 32'(ddr_address_o), 32'd0);
    chk("rst_vec_addr", 32'(vector_addr_o), 32'd0);
    chk("rst_wdata", 32'(ddr_w_data_o), 32'd0);

    // LDV from base 0
    seed_ddr(); clear_counts();
    run_cmd(LDV, 8'd0, cyc);
    check_ldv();
    chk("ldv_vec_writes", 32'(vw_cnt), D);
    chk("ldv_latency_ok", {31'b0, cyc <= 8 * D}, 32'd1);

    // SV from base 0: data, pulse count and address order
    seed_vec(); clear_counts();
    run_cmd(SV, 8'd0, cyc);
    check_sv(0);
    chk("sv_w_pulses", 32'(w_cnt), D);
    for (int i = 0; i < D; i++)
      chk($sformatf("sv_addr%0d", i), (i < wlog.size()) ? 32'(wlog[i]) : 32'hffff_ffff, 32'(i));
    chk("sv_no_vec_writes", 32'(vw_cnt), 32'd0);

    // Five alternating commands back-to-back
    total = 0;
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) begin
        seed_ddr();
        run_cmd(LDV, ddr_address_t'(k * 16), cyc);
        check_ldv();
      end else begin
        seed_vec();
        run_cmd(SV, ddr_address_t'(k * 16), cyc);
        check_sv(k * 16);
      end
      total += cyc;
    end
    chk("b2b_total_ok", {31'b0, total < 40 * D}, 32'd1);

    // SV at max address wraps to 0
    seed_vec();
    run_cmd(SV, 8'hff, cyc);
    chk("wrap_elem0", 32'(ddr_mem[255]), 32'(ddr_data_t'(vec_seed[0])));
    chk("wrap_elem1", 32'(ddr_mem[0]),   32'(ddr_data_t'(vec_seed[1])));
    chk("wrap_elem7", 32'(ddr_mem[6]),   32'(ddr_data_t'(vec_seed[7])));

    // Reset while in LD_WAIT
    seed_vec(); seed_ddr(); clear_counts();
    in_valid_i = 1'b1; vector_operation_i = LDV; vector_memory_address_i = 8'd0;
    tick(1);
    in_valid_i = 1'b0;
    cyc = 0;
    while (!ddr_r_en_o && cyc < 10) begin tick(1); cyc++; end
    chk("rst_mid_saw_req", {31'b0, ddr_r_en_o}, 32'd1);
    tick(1);                    // now waiting for read data
    rst_i = 1'b1; tick(1); rst_i = 1'b0;
    chk("rst_mid_ready", {31'b0, in_ready_o}, 32'd1);
    tick(6);
    chk("rst_mid_no_vwrite", 32'(vw_cnt), 32'd0);
    chk("rst_mid_one_read", 32'(r_cnt), 32'd1);
    chk("rst_mid_vec0", 32'(ddr_data_t'(vec[0])), 32'(ddr_data_t'(vec_seed[0])));

    // in_valid_i while busy is dropped, SV completes normally
    seed_vec(); clear_counts();
    in_valid_i = 1'b1; vector_operation_i = SV; vector_memory_address_i = 8'd40;
    tick(1);
    in_valid_i = 1'b0;
    tick(3);
    in_valid_i = 1'b1; vector_operation_i = LDV; vector_memory_address_i = 8'd0;
    tick(2);
    in_valid_i = 1'b0;
    cyc = 0;
    while (!in_ready_o && cyc < 20 * D) begin tick(1); cyc++; end
    chk("busy_done", {31'b0, in_ready_o}, 32'd1);
    tick(8);
    check_sv(40);
    chk("busy_no_reads", 32'(r_cnt), 32'd0);
    chk("busy_w_pulses", 32'(w_cnt), D);

    // Unknown operation completes with no traffic
    clear_counts();
    run_cmd(load_store_operation_t'(2'd2), 8'd0, cyc);
    tick(4);
    chk("nop_traffic", 32'(w_cnt + r_cnt + vw_cnt), 32'd0);
    chk("nop_ready", {31'b0, in_ready_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vector_load_store.md
VECTOR_LOAD_STORE -- requirements
Module: vector_load_store

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 in_valid_i  input  1  command valid.
REQ-005 in_ready_o  output  1  high only when idle and able to accept a command.
REQ-006 vector_operation_i  input  load_store_operation_t  LDV (DDR -> vector) or SV (vector -> DDR).
REQ-007 vector_memory_address_i  input  ddr_address_t  DDR base address of element 0.
REQ-008 vector_addr_o  output  $clog2(D)  vector register element index.
REQ-009 vector_w_en_o  output  1  vector element write strobe.
REQ-010 vector_w_data_o  output  fixed_point_t  vector element write data.
REQ-011 vector_r_data_i  input  fixed_point_t  combinational read of element vector_addr_o.
REQ-012 ddr_address_o  output  ddr_address_t  DDR word address.
REQ-013 ddr_w_en_o  output  1  one-cycle DDR write request pulse.
REQ-014 ddr_w_data_o  output  ddr_data_t  DDR write data.
REQ-015 ddr_w_done_i  input  1  one-cycle DDR write completion.
REQ-016 ddr_r_en_o  output  1  one-cycle DDR read request pulse.
REQ-017 ddr_r_data_i  input  ddr_data_t  DDR read data, valid with ddr_r_valid_i.
REQ-018 ddr_r_valid_i  input  1  one-cycle DDR read data valid.

Function
REQ-019 One command moves all D elements of the vector register, one per DDR word; element i <-> DDR address base+i, wrapping modulo the ddr_address_t width.
REQ-020 Element width equals ddr_data_t width; data passes unmodified in both directions.
REQ-021 Command accepted on a cycle with in_valid_i && in_ready_o; operation and base address latched; in_ready_o low from the next cycle until completion.
REQ-022 in_valid_i while busy SHALL be ignored (not queued).
REQ-023 FSM states: IDLE, SV_READ, SV_REQ, SV_WAIT, LD_REQ, LD_WAIT, LD_WRITE; element counter i resets to 0 on accept.
REQ-024 SV per element: SV_READ drives vector_addr_o=i and registers vector_r_data_i into ddr_w_data_o; SV_REQ pulses ddr_w_en_o for one cycle with ddr_address_o=base+i; SV_WAIT holds address/data until ddr_w_done_i, then increments i and goes to SV_READ, or to IDLE after element D-1.
REQ-025 LDV per element: LD_REQ pulses ddr_r_en_o for one cycle with ddr_address_o=base+i; LD_WAIT holds address until ddr_r_valid_i and registers ddr_r_data_i; LD_WRITE asserts vector_w_en_o for one cycle with vector_addr_o=i and the registered data, then next element or IDLE after D-1.
REQ-026 At most one DDR request outstanding; no new request before the prior done/valid.
REQ-027 ddr_w_done_i/ddr_r_valid_i arriving in any non-waiting state SHALL be ignored.
REQ-028 Operation values other than LDV/SV SHALL complete immediately (back to IDLE next cycle) with no memory or vector traffic.
REQ-029 All memory effects of a command (last DDR write done or last vector write) SHALL occur before in_ready_o rises.
REQ-030 With a 2-cycle DDR response latency, a command SHALL finish within 8*D cycles.
REQ-031 vector_w_en_o, ddr_w_en_o, ddr_r_en_o SHALL be low in IDLE and in every state not listed as asserting them.

Reset
REQ-032 Reset SHALL force IDLE, i=0, in_ready_o=1 on the following cycle, all enables 0, addresses and data outputs 0.
REQ-033 Reset mid-command SHALL abort it immediately; late ddr_w_done_i/ddr_r_valid_i afterwards are ignored.

Structure
REQ-034 config_pkg SHALL hold D, fixed_point_t, vector_t, ddr_address_t, ddr_data_t, load_store_operation_t (LDV, SV).
REQ-035 Single module with one FSM; no sub-module.

Verification
REQ-036 Bench memory with 2-cycle latency: random DDR words 0..D-1, LDV base 0 -> vector[i]==ddr[i] for all i when in_ready_o rises.
REQ-037 Random vector, SV base 0 -> ddr[i]==vector[i] for all i; exactly D ddr_w_en_o pulses, addresses 0..D-1 in order.
REQ-038 Five alternating LDV/SV commands back-to-back -> all match, total under 40*D cycles.
REQ-039 SV with base = max address -> element 1 written to address 0 (wrap).
REQ-040 Reset asserted in LD_WAIT -> next cycle IDLE, in_ready_o=1, no vector write; in_valid_i pulsed during a busy SV -> ignored, SV completes normally.
